fanin_merge: RTL and testbench



---
 rtl/fanin_merge.sv | 171 +++++++++++++++++
 tb/tb_fanin_merge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fanin_merge.sv
// Registered N-to-1 round-robin stream merge with a 2-entry output buffer; words carry source index.
// Define FANIN_MERGE_LOCK_EN to hold the grant on one source until a word with the top bit set.
module fanin_merge #(
    parameter int unsigned NUM_IN     = 9,
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned SRC_W      = $clog2(NUM_IN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_IN-1:0]              in_en_i,
    input  logic [NUM_IN-1:0]              in_sel_i,
    input  logic [NUM_IN-1:0]              in_valid_i,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data_i,
    output logic [NUM_IN-1:0]              in_ready_o,
    output logic                           out_valid_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic [SRC_W-1:0]               out_src_o,
    input  logic                           out_ready_i
);

    logic [NUM_IN-1:0]     connected;
    logic [NUM_IN-1:0]     lock_mask;
    logic [NUM_IN-1:0]     eligible;
    logic [NUM_IN-1:0]     grant;
    logic [SRC_W-1:0]      grant_idx;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  space;
    logic                  push;
    logic                  pop;
    logic                  advance;

    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [SRC_W-1:0]      head_src_q, head_src_d;
    logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
    logic [SRC_W-1:0]      tail_src_q, tail_src_d;

    assign connected = in_en_i & in_sel_i;
    assign eligible  = connected & in_valid_i & lock_mask;

    // First eligible source at or after ptr, modulo NUM_IN.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            idx = (32'(ptr_q) + k) % NUM_IN;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                push_data = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign space      = (count_q < 2'd2);
    // Gated by rst_n so no source sees ready while the block is held in reset.
    assign in_ready_o = (space && rst_n) ? grant : '0;
    assign push       = |in_ready_o;
    assign pop        = valid_q & out_ready_i;

`ifdef FANIN_MERGE_LOCK_EN
    logic             lock_q, lock_d;
    logic [SRC_W-1:0] lock_src_q, lock_src_d;

    assign lock_mask = lock_q ? (NUM_IN'(1) << lock_src_q) : '1;
    assign advance   = push_data[DATA_WIDTH-1];

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (push) begin
            lock_d     = ~push_data[DATA_WIDTH-1];
            lock_src_d = grant_idx;
        end else if (lock_q && !connected[lock_src_q]) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_src_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end
`else
    assign lock_mask = '1;
    assign advance   = 1'b1;
`endif

    always_comb begin
        ptr_d = ptr_q;
        if (push && advance) begin
            ptr_d = (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Push never coincides with count==2 and pop never with count==0.
    always_comb begin
        head_data_d = head_data_q;
        head_src_d  = head_src_q;
        tail_data_d = tail_data_q;
        tail_src_d  = tail_src_q;
        count_d     = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d = push_data;
                    head_src_d  = grant_idx;
                end else begin
                    tail_data_d = push_data;
                    tail_src_d  = grant_idx;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_src_d  = tail_src_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                head_data_d = push_data;
                head_src_d  = grant_idx;
            end
            default: ;
        endcase
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            head_data_q <= '0;
            head_src_q  <= '0;
            tail_data_q <= '0;
            tail_src_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            head_data_q <= head_data_d;
            head_src_q  <= head_src_d;
            tail_data_q <= tail_data_d;
            tail_src_q  <= tail_src_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = head_data_q;
    assign out_src_o   = head_src_q;

endmodule

// File: tb/tb_fanin_merge.sv
// Directed self-checking bench for fanin_merge (9 sources, 17-bit words).
module tb_fanin_merge;

    localparam int unsigned N  = 9;
    localparam int unsigned DW = 17;
    localparam int unsigned SW = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      in_en;
    logic [N-1:0]      in_sel;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_ready;
    logic [DW-1:0]     dat [N];

    int n_checks;
    int n_fail;

    fanin_merge #(
        .NUM_IN     (N),
        .DATA_WIDTH (DW),
        .SRC_W      (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_en_i     (in_en),
        .in_sel_i    (in_sel),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = dat[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = '0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Expect source s granted this cycle and its word d at the head after the edge.
    task automatic cyc(input int s, input logic [DW-1:0] d);
        #1;
        check("grant", 32'(in_ready), 32'(1) << s);
        step();
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_src", 32'(out_src), 32'(s));
        check("out_data", 32'(out_data), 32'(d));
    endtask

    initial begin
        int rr_seq [6];
        int mk_seq [4];
        int lk_seq [4];
        logic [DW-1:0] words [3];
        int w3;
        int s;
        logic [DW-1:0] d;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_en     = '1;
        in_sel    = '1;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) dat[i] = DW'(17'h10100 + i);

        // Reset held with every source valid.
        step();
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        rst_n = 1'b1;
        cyc(0, 17'h10100);

        // Round-robin over sources 1, 4, 8.
        do_reset();
        in_valid = 9'b1_0001_0010;
        rr_seq = '{1, 4, 8, 1, 4, 8};
        for (int k = 0; k < 6; k++) cyc(rr_seq[k], DW'(17'h10100 + rr_seq[k]));

        // Source 4 deselected: it must never be granted.
        in_sel[4] = 1'b0;
        mk_seq = '{1, 8, 1, 8};
        for (int k = 0; k < 4; k++) cyc(mk_seq[k], DW'(17'h10100 + mk_seq[k]));
        in_valid  = '0;
        in_sel    = '1;

        // Source 0 disabled and the only one valid.
        do_reset();
        in_en    = ~9'b1;
        in_valid = 9'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("dis_in_ready", 32'(in_ready), 32'd0);
            step();
            check("dis_out_valid", 32'(out_valid), 32'd0);
        end
        in_en = '1;

        // Backpressure: two words fill the buffer, the third stalls.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 9'b100;
        dat[2]    = 17'h0000A;
        #1;
        check("bp_rdy_a", 32'(in_ready), 32'h4);
        step();
        dat[2] = 17'h0000B;
        #1;
        check("bp_rdy_b", 32'(in_ready), 32'h4);
        step();
        dat[2] = 17'h0000C;
        #1;
        check("bp_full_rdy", 32'(in_ready), 32'd0);
        check("bp_head_a", 32'(out_data), 32'h0000A);
        step();
        check("bp_hold_rdy", 32'(in_ready), 32'd0);
        check("bp_hold_a", 32'(out_data), 32'h0000A);
        check("bp_hold_v", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_pop_rdy", 32'(in_ready), 32'd0);
        step();
        check("bp_head_b", 32'(out_data), 32'h0000B);
        check("bp_release", 32'(in_ready), 32'h4);
        step();
        check("bp_head_c", 32'(out_data), 32'h0000C);
        in_valid = '0;
        step();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Source 3 sends a three-word packet while source 5 competes.
        do_reset();
        words  = '{17'h00005, 17'h00006, 17'h10007};
        w3     = 0;
        dat[3] = words[0];
        dat[5] = 17'h10055;
`ifdef FANIN_MERGE_LOCK_EN
        lk_seq = '{3, 3, 3, 5};
`else
        lk_seq = '{3, 5, 3, 5};
`endif
        in_valid = 9'b0_0010_1000;
        for (int k = 0; k < 4; k++) begin
            s = lk_seq[k];
            d = (s == 3) ? words[w3] : 17'h10055;
            cyc(s, d);
            if (s == 3 && w3 < 2) begin
                w3++;
                dat[3] = words[w3];
            end
        end
        in_valid = '0;

        // Reset asserted with the buffer full.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 9'b100;
        dat[2]    = 17'h000AA;
        step();
        step();
        check("mr_full_v", 32'(out_valid), 32'd1);
        check("mr_full_rdy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mr_async_v", 32'(out_valid), 32'd0);
        check("mr_async_data", 32'(out_data), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        step();
        check("mr_no_stale", 32'(out_valid), 32'd0);
        dat[2]   = 17'h10022;
        dat[8]   = 17'h10088;
        in_valid = 9'b1_0000_0100;
        cyc(2, 17'h10022);
        in_valid = '0;
        step();
        check("mr_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
